rolhas_transfer_ctrl: RTL and testbench

ROLHAS_TRANSFER_CTRL -- requirements
Module: rolhas_transfer_ctrl

---
 rtl/rolhas_transfer_ctrl_pkg.sv | 21 ++
 rtl/rolhas_transfer_ctrl_bin7_to_bcd.sv | 29 ++
 rtl/rolhas_transfer_ctrl.sv | 110 +++++++++++
 tb/tb_rolhas_transfer_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rolhas_transfer_ctrl_pkg.sv
// Shared constants and state encoding for the cork transfer controller.
// The optional BCD output is enabled by defining ROLHAS_BCD_OUT_EN.
package rolhas_transfer_ctrl_pkg;

  localparam logic [6:0] TRANSFER_MIN = 7'd20;
  localparam logic [3:0] DISP_MAX     = 4'd15;
  localparam logic [6:0] RES_MAX      = 7'd99;
  localparam logic [3:0] DISP_LAST    = DISP_MAX - 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSFER = 2'd1,
    ST_SETTLE   = 2'd2
  } state_e;

  // Clamp an unsaturated reservoir sum to the reservoir capacity.
  function automatic logic [6:0] sat_res(input logic [7:0] sum);
    return (sum > {1'b0, RES_MAX}) ? RES_MAX : sum[6:0];
  endfunction

endpackage

// File: rtl/rolhas_transfer_ctrl_bin7_to_bcd.sv
// Combinational binary (0..99) to two-digit BCD converter (double dabble).
// Only compiled when ROLHAS_BCD_OUT_EN is defined.
`ifdef ROLHAS_BCD_OUT_EN
module bin7_to_bcd (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [3:0] tens_c;
  logic [3:0] units_c;

  // The hundreds digit is never needed because the reservoir saturates at 99.
  always_comb begin
    tens_c  = 4'd0;
    units_c = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (units_c >= 4'd5) units_c = units_c + 4'd3;
      if (tens_c >= 4'd5)  tens_c  = tens_c + 4'd3;
      tens_c  = {tens_c[2:0], units_c[3]};
      units_c = {units_c[2:0], bin_i[i]};
    end
  end

  assign tens_o  = tens_c;
  assign units_o = units_c;

endmodule
`endif

// File: rtl/rolhas_transfer_ctrl.sv
// Cork reservoir/dispenser controller: batch refill FSM plus single-cork seal grants.
// Define ROLHAS_BCD_OUT_EN to drive registered BCD digits of the reservoir count.
module rolhas_transfer_ctrl
  import rolhas_transfer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load_en,
  input  logic [6:0] load_val,
  input  logic       seal_req,
  output logic       seal_ack,
  output logic [6:0] reg_r,
  output logic [3:0] reg_d,
  output logic       transfer_busy,
  output logic       refill_alarm,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units
);

  state_e     state_q, state_d;
  logic [6:0] res_q, res_d;
  logic [3:0] disp_q, disp_d;
  logic       ack_q, ack_d;
  logic       alarm_q, alarm_d;
  logic       grant;
  logic       start;
  logic [7:0] res_sum;

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ack_d   = 1'b0;
    grant   = (state_q == ST_IDLE) && enable && seal_req && (disp_q != 4'd0) && !ack_q;
    start   = (state_q == ST_IDLE) && enable && (disp_q == 4'd0) && (res_q >= TRANSFER_MIN);
    res_sum = {1'b0, res_q} + (load_en ? {1'b0, load_val} : 8'd0);

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          ack_d  = 1'b1;
          disp_d = disp_q - 4'd1;
        end else if (start) begin
          state_d = ST_TRANSFER;
        end
      end
      ST_TRANSFER: begin
        // A load in the same cycle is folded into the sum so no cork is lost.
        res_sum = res_sum - 8'd1;
        disp_d  = disp_q + 4'd1;
        if (disp_q == DISP_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    res_d   = sat_res(res_sum);
    alarm_d = (state_d == ST_IDLE) && (disp_d == 4'd0) && (res_d < TRANSFER_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= 7'd0;
      disp_q  <= 4'd0;
      ack_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      ack_q   <= ack_d;
      alarm_q <= alarm_d;
    end
  end

  assign seal_ack      = ack_q;
  assign reg_r         = res_q;
  assign reg_d         = disp_q;
  assign transfer_busy = (state_q == ST_TRANSFER) || (state_q == ST_SETTLE);
  assign refill_alarm  = alarm_q;

`ifdef ROLHAS_BCD_OUT_EN
  logic [3:0] tens_c, units_c;
  logic [3:0] tens_q, units_q;

  bin7_to_bcd u_bin7_to_bcd (
    .bin_i   (res_q),
    .tens_o  (tens_c),
    .units_o (units_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_c;
      units_q <= units_c;
    end
  end

  assign bcd_tens  = tens_q;
  assign bcd_units = units_q;
`else
  assign bcd_tens  = 4'd0;
  assign bcd_units = 4'd0;
`endif

endmodule

// File: tb/tb_rolhas_transfer_ctrl.sv
// Directed scoreboard bench for rolhas_transfer_ctrl (honours ROLHAS_BCD_OUT_EN for BCD expectations).
module tb_rolhas_transfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_en;
  logic [6:0] load_val;
  logic       seal_req;
  logic       seal_ack;
  logic [6:0] reg_r;
  logic [3:0] reg_d;
  logic       transfer_busy;
  logic       refill_alarm;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  rolhas_transfer_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .load_en       (load_en),
    .load_val      (load_val),
    .seal_req      (seal_req),
    .seal_ack      (seal_ack),
    .reg_r         (reg_r),
    .reg_d         (reg_d),
    .transfer_busy (transfer_busy),
    .refill_alarm  (refill_alarm),
    .bcd_tens      (bcd_tens),
    .bcd_units     (bcd_units)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_underflow: observed %0d, required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
    end
    $display("check %s observed %0d expected %0d", e.tag, obs, e.val);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    load_en  = 1'b0;
    load_val = 7'd0;
    seal_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [6:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick();
    load_en  = 1'b0;
    load_val = 7'd0;
  endtask

  // Counts busy cycles until the controller is idle again, bounded.
  task automatic run_transfer(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (transfer_busy) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    int n;
    int acks;
    int consec;
    logic prev;

    // Reset state
    push("rst_reg_r", 0); push("rst_reg_d", 0); push("rst_ack", 0); push("rst_busy", 0);
    push("rst_alarm", 0); push("rst_bcd_tens", 0); push("rst_bcd_units", 0);
    do_reset();
    pop_check(reg_r); pop_check(reg_d); pop_check(seal_ack); pop_check(transfer_busy);
    pop_check(refill_alarm); pop_check(bcd_tens); pop_check(bcd_units);

    // Full transfer from 30 corks
    enable = 1'b1;
    push("s1_busy_cycles", 16); push("s1_reg_r", 15); push("s1_reg_d", 15); push("s1_alarm", 0);
    load(7'd30);
    run_transfer(n);
    pop_check(n); pop_check(reg_r); pop_check(reg_d); pop_check(refill_alarm);

    // Below threshold: no transfer, alarm; topping up to 20 starts one
    do_reset();
    enable = 1'b1;
    push("s2_reg_r_low", 15); push("s2_busy_low", 0); push("s2_alarm_low", 1);
    load(7'd15);
    tick(); tick(); tick();
    pop_check(reg_r); pop_check(transfer_busy); pop_check(refill_alarm);
    push("s2_reg_r_20", 20); push("s2_busy_cycles", 16); push("s2_reg_r_end", 5); push("s2_reg_d_end", 15);
    load(7'd5);
    pop_check(reg_r);
    run_transfer(n);
    pop_check(n); pop_check(reg_r); pop_check(reg_d);

    // Seal request held 10 cycles from a full dispenser
    push("s3_ack_pulses", 5); push("s3_back_to_back", 0); push("s3_reg_d", 10);
    acks = 0; consec = 0; prev = 1'b0;
    seal_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seal_ack) acks++;
      if (seal_ack && prev) consec++;
      prev = seal_ack;
    end
    seal_req = 1'b0;
    pop_check(acks); pop_check(consec); pop_check(reg_d);

    // Saturating load during transfer
    do_reset();
    enable = 1'b1;
    push("s4a_busy", 1); push("s4a_sat", 99); push("s4a_reg_r_end", 85);
    load(7'd95);
    tick();
    pop_check(transfer_busy);
    load(7'd10);
    pop_check(reg_r);
    run_transfer(n);
    pop_check(reg_r);

    // Non-saturating load mid-transfer keeps every cork
    do_reset();
    enable = 1'b1;
    push("s4b_reg_r_end", 28); push("s4b_reg_d_end", 15);
    load(7'd40);
    tick(); tick(); tick(); tick();
    load(7'd3);
    run_transfer(n);
    pop_check(reg_r); pop_check(reg_d);

    // Reset in the 7th transfer cycle
    do_reset();
    enable = 1'b1;
    push("s5_busy_before", 1); push("s5_reg_d_before", 6);
    push("s5_busy", 0); push("s5_reg_r", 0); push("s5_reg_d", 0); push("s5_ack", 0); push("s5_alarm", 0);
    load(7'd30);
    tick();
    for (int i = 0; i < 6; i++) tick();
    pop_check(transfer_busy); pop_check(reg_d);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pop_check(transfer_busy); pop_check(reg_r); pop_check(reg_d); pop_check(seal_ack); pop_check(refill_alarm);

    // BCD output, enable low so the reservoir stays put
    do_reset();
    enable = 1'b0;
    push("s6_reg_r", 87); push("s6_busy", 0);
`ifdef ROLHAS_BCD_OUT_EN
    push("s6_tens_87", 8); push("s6_units_87", 7);
`else
    push("s6_tens_87", 0); push("s6_units_87", 0);
`endif
    load(7'd87);
    tick();
    pop_check(reg_r); pop_check(transfer_busy); pop_check(bcd_tens); pop_check(bcd_units);
    push("s6_clamp_127", 99);
`ifdef ROLHAS_BCD_OUT_EN
    push("s6_tens_99", 9); push("s6_units_99", 9);
`else
    push("s6_tens_99", 0); push("s6_units_99", 0);
`endif
    load(7'd127);
    pop_check(reg_r);
    tick();
    pop_check(bcd_tens); pop_check(bcd_units);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_leftover: observed %0d entries, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
